// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/gnt/rvalid access, load formatting and MEM/WB registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MEM_valid_i,
    input  logic                  MEM_regwrite_i,
    input  logic                  MEM_memread_i,
    input  logic                  MEM_memwrite_i,
    input  logic [2:0]            MEM_funct3_i,
    input  logic [31:0]           MEM_pc_i,
    input  logic [31:0]           MEM_imm_i,
    input  logic [4:0]            MEM_rd_add_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_store_data_i,
    input  logic [1:0]            MEM_sel_to_reg_i,
    output logic                  MEM_stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  WB_regwrite_o,
    output logic [31:0]           WB_pc_o,
    output logic [31:0]           WB_imm_o,
    output logic [4:0]            WB_rd_add_o,
    output logic [DATA_WIDTH-1:0] WB_alu_result_o,
    output logic [DATA_WIDTH-1:0] WB_load_data_o,
    output logic [1:0]            WB_sel_to_reg_o,
    output logic                  MEM_misalign_o
);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

    state_e state_q, state_d;

    logic        mem_op, is_load, is_store, misalign, access;
    logic        req, complete;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign off      = MEM_alu_result_i[1:0];
    assign is_load  = MEM_memread_i;
    assign is_store = MEM_memwrite_i & ~MEM_memread_i;
    assign mem_op   = MEM_valid_i & (MEM_memread_i | MEM_memwrite_i);

`ifdef MEM_MISALIGN_TRAP_EN
    logic half_op;
    assign half_op  = is_load ? (MEM_funct3_i == 3'b001 || MEM_funct3_i == 3'b101)
                              : (MEM_funct3_i == 3'b001);
    assign misalign = mem_op & ((half_op & off[0]) | ((MEM_funct3_i == 3'b010) & (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // A trapped access completes at once without touching memory.
    assign access = mem_op & ~misalign;

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    req = 1'b1;
                    if (dmem_gnt_i) begin
                        if (is_load) state_d = StWaitRvalid;
                        else         complete = 1'b1;
                    end else begin
                        state_d = StWaitGnt;
                    end
                end else if (MEM_valid_i) begin
                    complete = 1'b1;
                end
            end
            StWaitGnt: begin
                req = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_load) begin
                        state_d = StWaitRvalid;
                    end else begin
                        state_d  = StIdle;
                        complete = 1'b1;
                    end
                end
            end
            StWaitRvalid: begin
                if (dmem_rvalid_i) begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    assign dmem_req_o  = rst_n & req;
    assign MEM_stall_o = rst_n & access & ~complete;

    always_comb begin
        unique case (off)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (MEM_funct3_i)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = dmem_rdata_i;
        endcase
    end

    always_comb begin
        case (MEM_funct3_i)
            3'b000: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{MEM_store_data_i[7:0]}};
            end
            3'b001: begin
                st_be    = off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{MEM_store_data_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = MEM_store_data_i;
            end
        endcase
    end

    assign dmem_we_o    = is_store;
    assign dmem_addr_o  = {MEM_alu_result_i[31:2], 2'b00};
    assign dmem_be_o    = is_store ? st_be : 4'b1111;
    assign dmem_wdata_o = st_wdata;

    // Non-completion edges insert a bubble: regwrite clears, payload holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_regwrite_o   <= 1'b0;
            WB_pc_o         <= '0;
            WB_imm_o        <= '0;
            WB_rd_add_o     <= '0;
            WB_alu_result_o <= '0;
            WB_load_data_o  <= '0;
            WB_sel_to_reg_o <= '0;
            MEM_misalign_o  <= 1'b0;
        end else begin
            WB_regwrite_o  <= complete & MEM_regwrite_i & ~misalign;
            MEM_misalign_o <= complete & misalign;
            if (complete) begin
                WB_pc_o         <= MEM_pc_i;
                WB_imm_o        <= MEM_imm_i;
                WB_rd_add_o     <= MEM_rd_add_i;
                WB_alu_result_o <= MEM_alu_result_i;
                WB_load_data_o  <= ld_fmt;
                WB_sel_to_reg_o <= MEM_sel_to_reg_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a behavioural model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MEM_valid_i, MEM_regwrite_i, MEM_memread_i, MEM_memwrite_i;
    logic [2:0]  MEM_funct3_i;
    logic [31:0] MEM_pc_i, MEM_imm_i, MEM_alu_result_i, MEM_store_data_i;
    logic [4:0]  MEM_rd_add_i;
    logic [1:0]  MEM_sel_to_reg_i;
    logic        MEM_stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        WB_regwrite_o, MEM_misalign_o;
    logic [31:0] WB_pc_o, WB_imm_o, WB_alu_result_o, WB_load_data_o;
    logic [4:0]  WB_rd_add_o;
    logic [1:0]  WB_sel_to_reg_o;

    always #5 clk = ~clk;

    mem_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_valid_i(MEM_valid_i), .MEM_regwrite_i(MEM_regwrite_i),
        .MEM_memread_i(MEM_memread_i), .MEM_memwrite_i(MEM_memwrite_i),
        .MEM_funct3_i(MEM_funct3_i), .MEM_pc_i(MEM_pc_i), .MEM_imm_i(MEM_imm_i),
        .MEM_rd_add_i(MEM_rd_add_i), .MEM_alu_result_i(MEM_alu_result_i),
        .MEM_store_data_i(MEM_store_data_i), .MEM_sel_to_reg_i(MEM_sel_to_reg_i),
        .MEM_stall_o(MEM_stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .WB_regwrite_o(WB_regwrite_o), .WB_pc_o(WB_pc_o), .WB_imm_o(WB_imm_o),
        .WB_rd_add_o(WB_rd_add_o), .WB_alu_result_o(WB_alu_result_o),
        .WB_load_data_o(WB_load_data_o), .WB_sel_to_reg_o(WB_sel_to_reg_o),
        .MEM_misalign_o(MEM_misalign_o)
    );

    int checks = 0;
    int failures = 0;

    // Model of the MEM/WB register contents.
    logic [31:0] exp_pc, exp_imm, exp_alu, exp_ld;
    logic [4:0]  exp_rd;
    logic [1:0]  exp_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int unsigned b, h;
        b = (rdata >> (8 * addr[1:0])) & 32'hFF;
        h = (rdata >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4: return 32'(b);
            3'd5: return 32'(h);
            default: return rdata;
        endcase
    endfunction

    task automatic check_wb_hold(input string tag);
        chk({tag, "_bubble_rw"}, 32'(WB_regwrite_o), 32'd0);
        chk({tag, "_bubble_mis"}, 32'(MEM_misalign_o), 32'd0);
        chk({tag, "_hold_pc"}, WB_pc_o, exp_pc);
        chk({tag, "_hold_alu"}, WB_alu_result_o, exp_alu);
    endtask

    // One instruction from presentation to the edge after its completion.
    task automatic do_op(input string tag, input bit rd_en, input bit wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input bit rw, input int gd, input int rvd);
        bit load, store, mem, mis, acc;
        int comp;
        logic [3:0]  be_e;
        logic [31:0] wd_e, pc, imm;
        logic [4:0]  rd;
        logic [1:0]  sel;
        load  = rd_en;
        store = wr_en && !rd_en;
        mem   = rd_en || wr_en;
        mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (mem && addr[0] && (load ? (f3 == 3'd1 || f3 == 3'd5) : (f3 == 3'd1))) mis = 1'b1;
        if (mem && f3 == 3'd2 && addr[1:0] != 2'd0) mis = 1'b1;
`endif
        acc  = mem && !mis;
        comp = !acc ? 0 : (load ? gd + rvd : gd);
        be_e = 4'hF;
        wd_e = sdata;
        if (store && f3 == 3'd0) begin
            be_e = 4'(1 << addr[1:0]);
            wd_e = (sdata & 32'hFF) * 32'h0101_0101;
        end else if (store && f3 == 3'd1) begin
            be_e = 4'(3 << (2 * addr[1]));
            wd_e = (sdata & 32'hFFFF) * 32'h0001_0001;
        end
        pc  = $urandom;
        imm = $urandom;
        rd  = 5'($urandom);
        sel = 2'($urandom);
        for (int cyc = 0; cyc <= comp; cyc++) begin
            @(negedge clk);
            MEM_valid_i = 1'b1; MEM_regwrite_i = rw; MEM_memread_i = rd_en;
            MEM_memwrite_i = wr_en; MEM_funct3_i = f3; MEM_alu_result_i = addr;
            MEM_store_data_i = sdata; MEM_pc_i = pc; MEM_imm_i = imm;
            MEM_rd_add_i = rd; MEM_sel_to_reg_i = sel; dmem_rdata_i = rdata;
            dmem_gnt_i    = acc && cyc == gd;
            dmem_rvalid_i = acc && load && cyc == gd + rvd;
            #1;
            chk({tag, "_stall"}, 32'(MEM_stall_o), 32'(cyc != comp));
            chk({tag, "_req"}, 32'(dmem_req_o), 32'(acc && cyc <= gd));
            if (cyc == 0 && acc) begin
                chk({tag, "_addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
                chk({tag, "_be"}, 32'(dmem_be_o), 32'(be_e));
                chk({tag, "_we"}, 32'(dmem_we_o), 32'(store));
                if (store) chk({tag, "_wdata"}, dmem_wdata_o, wd_e);
            end
            @(posedge clk);
            #1;
            if (cyc == comp) begin
                exp_pc = pc; exp_imm = imm; exp_rd = rd; exp_alu = addr; exp_sel = sel;
                chk({tag, "_wb_rw"}, 32'(WB_regwrite_o), 32'(rw && !mis));
                chk({tag, "_wb_mis"}, 32'(MEM_misalign_o), 32'(mis));
                chk({tag, "_wb_pc"}, WB_pc_o, exp_pc);
                chk({tag, "_wb_imm"}, WB_imm_o, exp_imm);
                chk({tag, "_wb_rd"}, 32'(WB_rd_add_o), 32'(exp_rd));
                chk({tag, "_wb_alu"}, WB_alu_result_o, exp_alu);
                chk({tag, "_wb_sel"}, 32'(WB_sel_to_reg_o), 32'(exp_sel));
                if (load && !mis) begin
                    exp_ld = load_model(f3, addr, rdata);
                    chk({tag, "_wb_ld"}, WB_load_data_o, exp_ld);
                end
            end else begin
                check_wb_hold(tag);
            end
        end
        MEM_valid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        MEM_valid_i = 1'b0;
        #1;
        chk("idle_stall", 32'(MEM_stall_o), 32'd0);
        chk("idle_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk);
        #1;
        check_wb_hold("idle");
    endtask

    initial begin
        rst_n = 1'b0;
        MEM_valid_i = 0; MEM_regwrite_i = 0; MEM_memread_i = 0; MEM_memwrite_i = 0;
        MEM_funct3_i = 0; MEM_pc_i = 0; MEM_imm_i = 0; MEM_rd_add_i = 0;
        MEM_alu_result_i = 0; MEM_store_data_i = 0; MEM_sel_to_reg_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        exp_pc = 0; exp_imm = 0; exp_alu = 0; exp_ld = 0; exp_rd = 0; exp_sel = 0;
        #12;
        chk("rst_stall", 32'(MEM_stall_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_wb_rw", 32'(WB_regwrite_o), 32'd0);
        chk("rst_wb_pc", WB_pc_o, 32'd0);
        chk("rst_wb_ld", WB_load_data_o, 32'd0);
        chk("rst_mis", 32'(MEM_misalign_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        do_op("lb", 1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1, 0, 1);
        chk("lb_value", WB_load_data_o, 32'hFFFF_FF80);
        do_op("lhu", 1, 0, 3'd5, 32'h202, 32'h0, 32'hBEEF_0000, 1, 0, 1);
        chk("lhu_value", WB_load_data_o, 32'h0000_BEEF);
        do_op("lh", 1, 0, 3'd1, 32'h202, 32'h0, 32'hBEEF_0000, 1, 0, 1);
        chk("lh_value", WB_load_data_o, 32'hFFFF_BEEF);
        do_op("sb", 0, 1, 3'd0, 32'h31, 32'h0000_00AB, 32'h0, 0, 0, 0);
        do_op("sh", 0, 1, 3'd1, 32'h32, 32'h1234_5678, 32'h0, 0, 0, 0);
        do_op("sw_dly", 0, 1, 3'd2, 32'h40, 32'hCAFE_F00D, 32'h0, 1, 2, 0);
        do_op("lw_slow", 1, 0, 3'd2, 32'h80, 32'h0, 32'h1357_9BDF, 1, 3, 2);
        do_op("alu", 0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 0, 0);
        idle_cycle();

        // Reset while a load waits for rvalid; a late rvalid must be ignored.
        @(negedge clk);
        MEM_valid_i = 1; MEM_regwrite_i = 1; MEM_memread_i = 1; MEM_memwrite_i = 0;
        MEM_funct3_i = 3'd2; MEM_alu_result_i = 32'h300; MEM_pc_i = 32'h44;
        dmem_gnt_i = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        dmem_gnt_i = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(dmem_req_o), 32'd0);
        chk("arst_stall", 32'(MEM_stall_o), 32'd0);
        chk("arst_wb_pc", WB_pc_o, 32'd0);
        chk("arst_wb_alu", WB_alu_result_o, 32'd0);
        dmem_rvalid_i = 1;
        @(negedge clk);
        rst_n = 1'b1;
        MEM_valid_i = 0;
        #1;
        chk("late_rv_stall", 32'(MEM_stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("late_rv_wb_rw", 32'(WB_regwrite_o), 32'd0);
        chk("late_rv_wb_pc", WB_pc_o, 32'd0);
        chk("late_rv_wb_ld", WB_load_data_o, 32'd0);
        dmem_rvalid_i = 0;
        exp_pc = 0; exp_imm = 0; exp_alu = 0; exp_ld = 0; exp_rd = 0; exp_sel = 0;
        do_op("post_rst_alu", 0, 0, 3'd0, 32'h55, 32'h0, 32'h0, 1, 0, 0);

        do_op("lw_mis", 1, 0, 3'd2, 32'h102, 32'h0, 32'hA5A5_0F0F, 1, 0, 1);
        idle_cycle();

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            do_op("rnd", kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, 1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
